cache_hit_window_monitor: RTL

- Downstream statistics stage for the direct-mapped cache; consumes one access/hit strobe per cache access.
- Accumulates hits over fixed windows of WINDOW accesses and buffers each completed window record in a small FIFO.
- The logging/readout side drains records through a valid/ready port.
- Also keeps saturating lifetime totals for hits and accesses.

---
 rtl/cache_hit_window_monitor_if.sv | 26 ++
 rtl/cache_hit_window_monitor.sv | 83 ++++++++
 2 files changed

// File: rtl/cache_hit_window_monitor_if.sv
// cache_hit_window_monitor_if: access strobe, window-record readout and statistics bundle
interface cache_hit_window_monitor_if #(
    parameter int CNT_W = 21,
    parameter int FIFO_DEPTH = 8
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    logic access_valid;
    logic access_hit;
    logic clear;
    logic win_valid;
    logic win_ready;
    logic [15:0] win_index;
    logic [15:0] win_hits;
    logic [CNT_W-1:0] total_hits;
    logic [CNT_W-1:0] total_accesses;
    logic [7:0] drop_cnt;
    logic [LW-1:0] fifo_level;
    modport master (
        output access_valid, access_hit, clear, win_ready,
        input win_valid, win_index, win_hits, total_hits, total_accesses, drop_cnt, fifo_level
    );
    modport slave (
        input access_valid, access_hit, clear, win_ready,
        output win_valid, win_index, win_hits, total_hits, total_accesses, drop_cnt, fifo_level
    );
endinterface

// File: rtl/cache_hit_window_monitor.sv
// cache_hit_window_monitor: per-window hit counts queued in a FWFT FIFO plus saturating lifetime totals
module cache_hit_window_monitor #(
    parameter int WINDOW = 1000,
    parameter int CNT_W = 21,
    parameter int FIFO_DEPTH = 8
) (
    input logic clk,
    input logic rst_n,
    cache_hit_window_monitor_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    logic [15:0] acc_in_win, hit_in_win, next_index, rec_hits;
    logic [CNT_W-1:0] total_hits, total_accesses;
    logic [7:0] drop_cnt;
    logic [31:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic hit, close, full, pop, push, drop;

    // Window close and FIFO push/pop/drop decisions; a pop frees room for a same-cycle push
    always_comb begin
        hit = bus.access_valid & bus.access_hit;
        close = bus.access_valid && acc_in_win == 16'(WINDOW - 1);
        full = level == LW'(FIFO_DEPTH);
        pop = level != '0 && bus.win_ready;
        push = close && (!full || pop);
        drop = close && full && !pop;
        rec_hits = hit_in_win + 16'(hit);
    end

    // Window counters, window sequence number and saturating statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_in_win <= '0;
            hit_in_win <= '0;
            next_index <= '0;
            total_hits <= '0;
            total_accesses <= '0;
            drop_cnt <= '0;
        end else if (bus.clear) begin
            acc_in_win <= '0;
            hit_in_win <= '0;
            next_index <= '0;
            total_hits <= '0;
            total_accesses <= '0;
            drop_cnt <= '0;
        end else if (bus.access_valid) begin
            acc_in_win <= close ? '0 : acc_in_win + 16'd1;
            hit_in_win <= close ? '0 : rec_hits;
            next_index <= next_index + 16'(close);
            total_accesses <= total_accesses + CNT_W'(total_accesses != '1);
            total_hits <= total_hits + CNT_W'(hit && total_hits != '1);
            drop_cnt <= drop_cnt + 8'(drop && drop_cnt != '1);
        end
    end

    // Record FIFO; storage is zeroed only on reset so the head reads 0 out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (bus.clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
        end else begin
            if (push) mem[wr_ptr] <= {next_index, rec_hits};
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            level <= level + LW'(push) - LW'(pop);
        end
    end

    assign bus.win_valid = level != '0;
    assign {bus.win_index, bus.win_hits} = mem[rd_ptr];
    assign bus.total_hits = total_hits;
    assign bus.total_accesses = total_accesses;
    assign bus.drop_cnt = drop_cnt;
    assign bus.fifo_level = level;
endmodule
